// File: rtl/dmux4way16_reg_pkg.sv
// Shared constants and types for the registered 4-way 16-bit demultiplexer.
package dmux4way16_reg_pkg;

  localparam int WIDTH_DEFAULT = 16;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/dmux_slot16.sv
// One demux channel: a holding register plus a valid flag driven by a two-state FSM.
module dmux_slot16
  import dmux4way16_reg_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  slot_state_e state;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      dout  <= '0;
    end else if (load) begin
      // Load wins over drain: a same-cycle drain+load stays FULL with the new word.
      state <= FULL;
      dout  <= din;
    end else if (state == FULL && ready) begin
      state <= EMPTY;
    end
  end

  assign valid = (state == FULL);

endmodule

// File: rtl/dmux4way16_reg.sv
// Registered 1-to-4 demultiplexer with per-channel valid/ready handshake and an accept counter.
module dmux4way16_reg
  import dmux4way16_reg_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     c,
  output logic [WIDTH-1:0]     d,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] acc_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic             accept;
  logic [3:0]       load;
  logic [WIDTH-1:0] dout [4];

  // Only the addressed channel can stall the input; others never do.
  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    load = 4'b0000;
    if (accept) begin
      case (in_sel)
        SEL_A:   load = 4'b0001;
        SEL_B:   load = 4'b0010;
        SEL_C:   load = 4'b0100;
        SEL_D:   load = 4'b1000;
        default: load = 4'b0000;
      endcase
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_slot
    dmux_slot16 #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .reset (reset),
      .load  (load[k]),
      .din   (in_data),
      .ready (out_ready[k]),
      .dout  (dout[k]),
      .valid (out_valid[k])
    );
  end

  assign a    = dout[0];
  assign b    = dout[1];
  assign c    = dout[2];
  assign d    = dout[3];
  assign busy = |out_valid;

  // Free-running accept counter; wraps naturally at 2^CNT_WIDTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_count <= '0;
    end else if (accept) begin
      acc_count <= acc_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_dmux4way16_reg.sv
// Self-checking bench for dmux4way16_reg: table-driven vectors plus directed multi-cycle sequences.
module tb_dmux4way16_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready, in_ready_w;
  logic [15:0] a, b, c, d;
  logic [15:0] a_w, b_w, c_w, d_w;
  logic [3:0]  out_valid, out_valid_w;
  logic [3:0]  out_ready;
  logic        busy, busy_w;
  logic [15:0] acc_count;
  logic [3:0]  acc_count_w;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dmux4way16_reg dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .acc_count(acc_count)
  );

  // Narrow-counter instance sharing all inputs, used for the wrap check.
  dmux4way16_reg #(.CNT_WIDTH(4)) dut_w (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready_w), .a(a_w), .b(b_w), .c(c_w), .d(d_w), .out_valid(out_valid_w),
    .out_ready(out_ready), .busy(busy_w), .acc_count(acc_count_w)
  );

  typedef struct {
    logic [15:0] data;
    logic [1:0]  sel;
    logic        valid;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [15:0] exp_a, exp_b, exp_c, exp_d;
    logic [3:0]  exp_ov;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance to just after the next rising edge, where registered outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] data, input logic [1:0] sel, input logic valid,
                       input logic [3:0] ordy);
    in_data   = data;
    in_sel    = sel;
    in_valid  = valid;
    out_ready = ordy;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(16'h0, 2'b00, 1'b0, 4'b0000);

    //          data     sel    vld   ordy     rdy   a        b        c        d        ov       cnt
    vecs[0]  = '{16'h0001, 2'd0, 1'b1, 4'b1111, 1'b1, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 16'd1};
    vecs[1]  = '{16'h0002, 2'd1, 1'b1, 4'b1111, 1'b1, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 4'b0010, 16'd2};
    vecs[2]  = '{16'h0004, 2'd2, 1'b1, 4'b1111, 1'b1, 16'h0001, 16'h0002, 16'h0004, 16'h0000, 4'b0100, 16'd3};
    vecs[3]  = '{16'h0008, 2'd3, 1'b1, 4'b1111, 1'b1, 16'h0001, 16'h0002, 16'h0004, 16'h0008, 4'b1000, 16'd4};
    vecs[4]  = '{16'h0000, 2'd0, 1'b0, 4'b1111, 1'b1, 16'h0001, 16'h0002, 16'h0004, 16'h0008, 4'b0000, 16'd4};
    // Backpressure on channel a
    vecs[5]  = '{16'h1111, 2'd0, 1'b1, 4'b1110, 1'b1, 16'h1111, 16'h0002, 16'h0004, 16'h0008, 4'b0001, 16'd5};
    vecs[6]  = '{16'h2222, 2'd0, 1'b1, 4'b1110, 1'b0, 16'h1111, 16'h0002, 16'h0004, 16'h0008, 4'b0001, 16'd5};
    vecs[7]  = '{16'h3333, 2'd1, 1'b1, 4'b1110, 1'b1, 16'h1111, 16'h3333, 16'h0004, 16'h0008, 4'b0011, 16'd6};
    vecs[8]  = '{16'h2222, 2'd0, 1'b1, 4'b1111, 1'b1, 16'h2222, 16'h3333, 16'h0004, 16'h0008, 4'b0001, 16'd7};
    vecs[9]  = '{16'h0000, 2'd0, 1'b0, 4'b1111, 1'b1, 16'h2222, 16'h3333, 16'h0004, 16'h0008, 4'b0000, 16'd7};
    // Channel c: fill, hold with in_valid low, then drain+load in one cycle
    vecs[10] = '{16'hAAAA, 2'd2, 1'b1, 4'b1011, 1'b1, 16'h2222, 16'h3333, 16'hAAAA, 16'h0008, 4'b0100, 16'd8};
    vecs[11] = '{16'h5555, 2'd2, 1'b0, 4'b1011, 1'b0, 16'h2222, 16'h3333, 16'hAAAA, 16'h0008, 4'b0100, 16'd8};
    vecs[12] = '{16'hBBBB, 2'd2, 1'b1, 4'b1111, 1'b1, 16'h2222, 16'h3333, 16'hBBBB, 16'h0008, 4'b0100, 16'd9};
    vecs[13] = '{16'h0000, 2'd2, 1'b0, 4'b1111, 1'b1, 16'h2222, 16'h3333, 16'hBBBB, 16'h0008, 4'b0000, 16'd9};
    // Idle with in_sel on an empty channel: no state change
    vecs[14] = '{16'hFFFF, 2'd3, 1'b0, 4'b0000, 1'b1, 16'h2222, 16'h3333, 16'hBBBB, 16'h0008, 4'b0000, 16'd9};

    do_reset();
    check("reset_a", a, 16'h0);
    check("reset_b", b, 16'h0);
    check("reset_c", c, 16'h0);
    check("reset_d", d, 16'h0);
    check("reset_out_valid", out_valid, 4'b0000);
    check("reset_busy", busy, 1'b0);
    check("reset_acc_count", acc_count, 16'd0);

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].data, vecs[i].sel, vecs[i].valid, vecs[i].ordy);
      #1;
      check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].exp_rdy);
      tick();
      check($sformatf("v%0d_a", i), a, vecs[i].exp_a);
      check($sformatf("v%0d_b", i), b, vecs[i].exp_b);
      check($sformatf("v%0d_c", i), c, vecs[i].exp_c);
      check($sformatf("v%0d_d", i), d, vecs[i].exp_d);
      check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].exp_ov);
      check($sformatf("v%0d_busy", i), busy, |vecs[i].exp_ov);
      check($sformatf("v%0d_acc_count", i), acc_count, vecs[i].exp_cnt);
    end

    // Streaming 8 back-to-back words into channel d
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(16'h0010 + 16'(i), 2'd3, 1'b1, 4'b1000);
      #1;
      check($sformatf("stream%0d_in_ready", i), in_ready, 1'b1);
      tick();
      check($sformatf("stream%0d_d", i), d, 16'h0010 + 16'(i));
      check($sformatf("stream%0d_valid", i), out_valid, 4'b1000);
    end
    check("stream_acc_count", acc_count, 16'd8);

    // Fill all channels with consumers stalled, then reset alongside an accept
    in_valid = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(16'hC000 + 16'(i), 2'(i), 1'b1, 4'b0000);
      tick();
    end
    check("full_out_valid", out_valid, 4'b1111);
    check("full_busy", busy, 1'b1);
    check("full_c", c, 16'hC002);
    drive(16'hFFFF, 2'd0, 1'b1, 4'b0000);
    #1;
    check("full_in_ready", in_ready, 1'b0);
    drive(16'hFFFF, 2'd0, 1'b1, 4'b1111);
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    check("midreset_a", a, 16'h0);
    check("midreset_b", b, 16'h0);
    check("midreset_c", c, 16'h0);
    check("midreset_d", d, 16'h0);
    check("midreset_out_valid", out_valid, 4'b0000);
    check("midreset_busy", busy, 1'b0);
    check("midreset_acc_count", acc_count, 16'd0);
    check("midreset_acc_count_w", acc_count_w, 4'd0);

    // 17 accepts: narrow counter wraps to 1, wide one reaches 17
    for (int i = 0; i < 17; i++) begin
      drive(16'(i), 2'd0, 1'b1, 4'b1111);
      tick();
    end
    in_valid = 1'b0;
    check("wrap_acc_count_w", acc_count_w, 4'd1);
    check("wrap_acc_count", acc_count, 16'd17);
    check("wrap_a", a, 16'd16);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
